seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Display stage downstream of the CPU datapath. It captures the 16-bit datapath result
//  and shows all four hex nibbles on a 4-digit multiplexed seven-segment display.
//  Digits are scanned with a clock-divided refresh counter. Display updates are
//  tear-free: a new value is committed only at a frame boundary.
// PARAMETERS
//  CLK_DIV    50000  clk cycles each digit stays lit; legal range 2..2^20
//  BLANK_LZ   1      1 = blank leading-zero digits 3..1; digit 0 is never blanked
// PORTS
//  clk        in   1   system clock; all state changes on its rising edge
//  reset      in   1   asynchronous, active-high reset
//  value      in   16  datapath result to display
//  load       in   1   1-cycle strobe; capture value
//  seg        out  7   active-low segments {g,f,e,d,c,b,a}
//  an         out  4   active-low digit enables; an[0] = least-significant nibble
//  pending    out  1   captured value is waiting for the next frame boundary
//  commit     out  1   1-cycle pulse when the display register takes a new value
// BEHAVIOUR
//  Reset values (asynchronous):
//   - internal: div_cnt=0, digit=0, shadow=0, disp=0, pending=0
//   - outputs: seg=7'b1111111, an=4'b1111, commit=0
//  Divider and scan:
//   - div_cnt counts 0..CLK_DIV-1 and then wraps.
//   - tick = (div_cnt==CLK_DIV-1).
//   - digit advances 0->1->2->3->0 on each tick.
//   - frame boundary = tick && digit==3.
//  Outputs are registered, one cycle behind digit/disp:
//   - an = ~(4'b0001<<digit)
//   - seg = ~pattern(disp[4*digit+:4])
//   - After reset deasserts, the first edge gives an=1110 and seg=7'b1000000 ("0").
//  Segment table, active-high, 0..F:
//   3F 06 5B 4F 66 6D 7D 07 7F 67 77 7C 58 5E 79 71
//  Blanking:
//   - With BLANK_LZ=1, digit k (k=3..1) is blank (seg=7'h7F) when disp[15:4k]==0.
//   - an still asserts for a blanked digit, so scan timing is unchanged.
//  Capture (outside a frame-boundary cycle):
//   - load -> shadow<=value, pending<=1.
//   - Repeated loads before the boundary overwrite shadow; last writer wins.
//   - Only one commit follows.
//  Frame-boundary cycle:
//   - load=1 -> disp<=value (bypass, shadow also <=value), pending<=0, commit<=1.
//   - else if pending -> disp<=shadow, pending<=0, commit<=1.
//   - else -> no change, commit<=0.
//  Commit timing: commit is high in the cycle after the boundary edge, together with
//   the first digit-0 refresh of the new value.
//  Reset mid-frame or with pending=1: the pending value is discarded and the display
//   returns to 0000 (blanked per BLANK_LZ).
//  value is sampled only when load=1, so no combinational path exists from value to seg.
// STRUCTURE
//  - Include seg7_defs.vh holds the 16-entry segment table, SEG_BLANK=7'h7F and
//    AN_OFF=4'hF. This table is shared with every other hex display in the design.
//  - One sub-module: hex_to_seg7 (4-bit nibble in -> 7-bit active-high pattern,
//    purely combinational). The top inverts its output.
//  - Top holds the divider, the digit counter, the shadow/disp/pending registers,
//    the blanking logic and the output registers.
// TESTING (CLK_DIV=4, so one frame = 16 cycles)
//  1. Reset, then hold reset=0 for 32 cycles.
//     -> an cycles 1110,1101,1011,0111, each lit for 4 cycles.
//     -> BLANK_LZ=0: every seg sample is 7'h40.
//     -> BLANK_LZ=1: digits 3..1 read 7'h7F.
//  2. Pulse load with value=16'h12AF mid-frame.
//     -> pending=1 until the boundary, then commit pulses once.
//     -> Next frame segs: d0=0E (F), d1=08 (A), d2=24 (2), d3=79 (1).
//  3. Pulse load with 16'h0001, then load with 16'h0030 in the same frame.
//     -> Exactly one commit.
//     -> BLANK_LZ=1 shows d0=40, d1=30, d2/d3=7F.
//  4. Assert load with 16'hBEEF exactly on the boundary cycle.
//     -> commit on the next cycle; digit 0 shows F (0E) in that same cycle.
//     -> pending never rises.
//  5. Assert reset asynchronously mid-cycle while pending=1.
//     -> seg=7F and an=F immediately; pending=0; no commit.
//     -> After release, display returns to 0.
//  6. Run 3 frames with no load.
//     -> commit stays 0.
//     -> The an pattern is periodic every 16 cycles.
//     -> an is never 4'b1111 and never has more than one active digit.

Source files
------------

// File: rtl/seg7_scan_display_pkg.sv
// Shared types and constants for the seven-segment scan display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_scan_display_pkg;

    `include "seg7_defs.vh"

    typedef logic [1:0] digit_t;

    // Returns the active-high segment pattern for one hex nibble.
    function automatic logic [6:0] seg7_pattern(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_defs.vh
// Seven-segment constants shared by every hex display in the design.
// Include this file inside a package or module scope. It contains only localparams.
// Segment patterns are active-high, with bit order {g,f,e,d,c,b,a}.
localparam logic [6:0] SEG_BLANK = 7'h7F;
localparam logic [3:0] AN_OFF    = 4'hF;

// Entry n holds the pattern for hex digit n. Entry 0 is the rightmost element of the literal.
localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
};

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Hex nibble to seven-segment pattern decoder (active-high, {g,f,e,d,c,b,a}).
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
// Ports: nibble (4-bit hex digit in), pattern (7-bit active-high segments out).
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = seg7_pattern(nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display with a tear-free frame-boundary commit of the datapath result.
// Latency: an/seg are registered one cycle behind digit/disp. A load is shown at the next frame boundary.
// Backpressure: none. load is always accepted, and later loads in a frame overwrite the shadow value.
// Ports: clk, reset (async, active-high), value[15:0], load (strobe), seg[6:0] (active-low),
//        an[3:0] (active-low, an[0] = low nibble), pending, commit (pulse aligned with the new digit 0).
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        pending,
    output logic        commit
);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    digit_t           digit;
    logic [15:0]      shadow;
    logic [15:0]      disp;
    logic             commit_q;

    logic             tick;
    logic             boundary;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_pattern;
    logic             blank;
    logic [6:0]       seg_next;

    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (digit == 2'd3);

    assign cur_nibble = disp[{digit, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    // A digit is blank when it and every digit above it are zero. Digit 0 is never blank.
    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (digit)
                2'd3:    blank = (disp[15:12] == 4'h0);
                2'd2:    blank = (disp[15:8]  == 8'h00);
                2'd1:    blank = (disp[15:4]  == 12'h000);
                default: blank = 1'b0;
            endcase
        end
        seg_next = blank ? SEG_BLANK : ~cur_pattern;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            digit    <= '0;
            shadow   <= '0;
            disp     <= '0;
            pending  <= 1'b0;
            commit_q <= 1'b0;
            commit   <= 1'b0;
            seg      <= SEG_BLANK;
            an       <= AN_OFF;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                digit <= digit + 2'd1;
            end

            an  <= ~(4'b0001 << digit);
            seg <= seg_next;

            // commit_q marks the edge where disp changed. Delaying it one more stage
            // lines the commit pulse up with the first refresh of the new digit 0.
            commit <= commit_q;

            if (boundary) begin
                if (load) begin
                    // Bypass: a load that lands on the boundary is shown immediately.
                    disp     <= value;
                    shadow   <= value;
                    pending  <= 1'b0;
                    commit_q <= 1'b1;
                end else if (pending) begin
                    disp     <= shadow;
                    pending  <= 1'b0;
                    commit_q <= 1'b1;
                end else begin
                    commit_q <= 1'b0;
                end
            end else begin
                commit_q <= 1'b0;
                if (load) begin
                    shadow  <= value;
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with CLK_DIV=4 (16-cycle frame).
// Two instances run in parallel: one with leading-zero blanking enabled and one with it disabled.
// k counts rising edges since reset release. Outputs are sampled on the falling edge after edge k.
module tb_seg7_scan_display;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [6:0]  seg1, seg0;
    logic [3:0]  an1, an0;
    logic        pending1, pending0;
    logic        commit1, commit0;

    int tests_run = 0;
    int tests_failed = 0;
    int k = 0;

    // Expected seg per digit, before and after the commit of each span (blanking on / off).
    logic [6:0] exp_old [4];
    logic [6:0] exp_new [4];
    logic [6:0] exp0_old [4];
    logic [6:0] exp0_new [4];

    seg7_scan_display #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut_blank (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .seg(seg1), .an(an1), .pending(pending1), .commit(commit1)
    );

    seg7_scan_display #(.CLK_DIV(4), .BLANK_LZ(1'b0)) dut_noblank (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .seg(seg0), .an(an0), .pending(pending0), .commit(commit0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    // Runs up to edge k_hi. Loads are applied at edges ld1_k / ld2_k. The commit pulse
    // is expected at commit_k, and pending is expected high for pend_lo <= k < pend_hi.
    task automatic run_span(input int k_hi, input int ld1_k, input logic [15:0] v1,
                            input int ld2_k, input logic [15:0] v2, input int commit_k,
                            input int pend_lo, input int pend_hi);
        int d;
        logic [3:0] one;
        logic [3:0] an_exp;
        logic       use_new;
        one = 4'b0001;
        while (k < k_hi) begin
            load  = ((k + 1) == ld1_k) || ((k + 1) == ld2_k);
            value = ((k + 1) == ld2_k) ? v2 : v1;
            step();
            load = 1'b0;
            d = ((k - 1) >> 2) & 3;
            an_exp  = ~(one << d);
            use_new = (commit_k > 0) && (k >= commit_k);
            check_eq("an_blank", 32'(an1), 32'(an_exp));
            check_eq("an_noblank", 32'(an0), 32'(an_exp));
            check_eq("an_onehot", 32'($countones(~an1)), 32'd1);
            check_eq("seg_blank", 32'(seg1), 32'(use_new ? exp_new[d] : exp_old[d]));
            check_eq("seg_noblank", 32'(seg0), 32'(use_new ? exp0_new[d] : exp0_old[d]));
            check_eq("commit", 32'(commit1), 32'(k == commit_k));
            check_eq("pending", 32'(pending1), 32'((k >= pend_lo) && (k < pend_hi)));
        end
    endtask

    task automatic roll_expect();
        for (int i = 0; i < 4; i++) begin
            exp_old[i]  = exp_new[i];
            exp0_old[i] = exp0_new[i];
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_seg", 32'(seg1), 32'h7F);
        check_eq("rst_an", 32'(an1), 32'hF);
        check_eq("rst_commit", 32'(commit1), 32'd0);
        check_eq("rst_pending", 32'(pending1), 32'd0);

        reset = 1'b0;
        k = 0;

        // 1: idle scan of 0000
        exp_old  = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        exp0_old = '{7'h40, 7'h40, 7'h40, 7'h40};
        run_span(32, -1, 16'h0, -1, 16'h0, -1, -1, -1);

        // 2: mid-frame load of 12AF, committed at edge 48, visible from edge 49
        exp_new  = '{7'h0E, 7'h08, 7'h24, 7'h79};
        exp0_new = '{7'h0E, 7'h08, 7'h24, 7'h79};
        run_span(64, 37, 16'h12AF, -1, 16'h0, 49, 37, 48);
        roll_expect();

        // 3: two loads in one frame; the last one wins and only one commit follows
        exp_new  = '{7'h40, 7'h30, 7'h7F, 7'h7F};
        exp0_new = '{7'h40, 7'h30, 7'h40, 7'h40};
        run_span(95, 67, 16'h0001, 70, 16'h0030, 81, 67, 80);
        roll_expect();

        // 4: load exactly on the boundary edge 96 bypasses the shadow register
        exp_new  = '{7'h0E, 7'h06, 7'h06, 7'h03};
        exp0_new = '{7'h0E, 7'h06, 7'h06, 7'h03};
        run_span(112, 96, 16'hBEEF, -1, 16'h0, 97, -1, -1);
        roll_expect();

        // 5: leave a value pending, then assert reset asynchronously mid-cycle
        run_span(116, 115, 16'h1234, -1, 16'h0, -1, 115, 200);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_seg", 32'(seg1), 32'h7F);
        check_eq("arst_an", 32'(an1), 32'hF);
        check_eq("arst_pending", 32'(pending1), 32'd0);
        check_eq("arst_commit", 32'(commit1), 32'd0);
        check_eq("arst_seg_noblank", 32'(seg0), 32'h7F);
        repeat (2) @(posedge clk);
        #1;
        check_eq("arst_hold_an", 32'(an1), 32'hF);
        check_eq("arst_hold_commit", 32'(commit1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        k = 0;

        // 6: after release, three idle frames show 0000 with no commits
        exp_old  = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        exp0_old = '{7'h40, 7'h40, 7'h40, 7'h40};
        run_span(48, -1, 16'h0, -1, 16'h0, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
